// File: rtl/shift_add_mult_pkg.sv
// Shared types and sizing helpers for the shift-and-add multiplier sequencer.
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 4;

    // Bits needed to count 0..w-1 RUN cycles; never narrower than one bit.
    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/shift_add_mult_if.sv
// Request/response bundle for the sequential multiplier: start/a/b in, busy/done/product out.
interface shift_add_mult_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult_seq_times_two_unit.sv
// Combinational doubler: out = in * 2 with the MSB dropped. Reusable by other sequencers.
module times_two_unit #(
    parameter int W = 8
) (
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);
    assign out = {in[W-2:0], 1'b0};
endmodule

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-and-add multiplier, one multiplier bit per clock through a shared doubler.
// Define SHIFT_ADD_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module shift_add_mult_seq
    import shift_add_mult_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    shift_add_mult_if.slave bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [PW-1:0]     mcand_q, mcand_d;
    logic [PW-1:0]     acc_q, acc_d;
    logic [PW-1:0]     prod_q, prod_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [PW-1:0]     mcand_x2;
    logic              finish;

    times_two_unit #(.W(PW)) u_x2 (
        .in  (mcand_q),
        .out (mcand_x2)
    );

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        finish   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    mcand_d  = PW'(bus.a);
                    mplier_d = bus.b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_x2;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                finish   = (cnt_q == LAST);
`ifdef SHIFT_ADD_MULT_EARLY_TERM_EN
                finish   = finish || (mplier_d == '0);
`endif
                // Capture the post-add accumulator so product and done land together.
                if (finish) begin
                    state_d = ST_DONE;
                    prod_d  = acc_d;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = prod_q;

endmodule
